// File: rtl/msu_pkg.sv
// msu_pkg: shared MSU-1 buffer geometry used by the data buffer and the register block.
package msu_pkg;
    localparam int MSU_BUF_ADDR_W = 14;
    localparam int MSU_BUF_DATA_W = 8;
    localparam int MSU_BUF_DEPTH  = 16384;
    typedef logic [MSU_BUF_ADDR_W-1:0] msu_buf_addr_t;
    typedef logic [MSU_BUF_DATA_W-1:0] msu_buf_data_t;
endpackage

// File: rtl/msu_databuf_if.sv
// msu_databuf_if: write/read port bundle of the MSU-1 data buffer.
interface msu_databuf_if;
    import msu_pkg::*;
    logic          wren;
    msu_buf_addr_t wraddress;
    msu_buf_data_t data;
    msu_buf_addr_t rdaddress;
    msu_buf_data_t q;
    modport master (output wren, wraddress, data, rdaddress, input q);
    modport slave  (input wren, wraddress, data, rdaddress, output q);
endinterface

// File: rtl/msu_databuf_ram.sv
// msu_databuf_ram: inferable simple dual-port RAM with registered read and no reset.
module msu_databuf_ram
    import msu_pkg::*;
#(
    parameter int ADDR_W = MSU_BUF_ADDR_W,
    parameter int DATA_W = MSU_BUF_DATA_W
) (
    input  logic              clock,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rdaddress,
    output logic [DATA_W-1:0] rdata
);
    // Zero-initialised contents so never-written locations read back as 0.
    logic [DATA_W-1:0] mem_q [2**ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rdata_d, rdata_q;
    always_comb rdata_d = mem_q[rdaddress];
    // Read samples pre-write contents, giving old data on same-address collisions.
    always_ff @(posedge clock) begin
        if (wren) mem_q[wraddress] <= data;
        rdata_q <= rdata_d;
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/msu_databuf.sv
// msu_databuf: 16 KiB MSU-1 data buffer with reset-gated read data.
// Define MSU_DATABUF_OUTREG_EN to add a second output register (2-cycle read latency).
module msu_databuf
    import msu_pkg::*;
#(
    parameter int ADDR_W = MSU_BUF_ADDR_W,
    parameter int DATA_W = MSU_BUF_DATA_W
) (
    input  logic      clock,
    input  logic      reset,
    msu_databuf_if.slave bus
);
    logic [DATA_W-1:0] ram_q, rd_d;
    logic              vld_d, vld_q;
    msu_databuf_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clock    (clock),
        .wren     (bus.wren),
        .wraddress(bus.wraddress),
        .data     (bus.data),
        .rdaddress(bus.rdaddress),
        .rdata    (ram_q)
    );
    // The RAM read register has no reset; vld_q masks it for the cycle after reset.
    always_comb begin
        vld_d = !reset;
        rd_d  = vld_q ? ram_q : '0;
    end
    always_ff @(posedge clock) vld_q <= vld_d;
`ifdef MSU_DATABUF_OUTREG_EN
    logic [DATA_W-1:0] out_d, out_q;
    always_comb out_d = reset ? '0 : rd_d;
    always_ff @(posedge clock) out_q <= out_d;
    assign bus.q = out_q;
`else
    assign bus.q = rd_d;
`endif
endmodule

// File: tb/tb_msu_databuf.sv
// tb_msu_databuf: directed self-checking bench for msu_databuf in either latency build.
module tb_msu_databuf;
    import msu_pkg::*;
`ifdef MSU_DATABUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clock = 0;
    logic reset = 1;
    int   n_tests = 0;
    int   n_fail  = 0;
    msu_databuf_if bus();
    msu_databuf dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    logic [7:0] pat [16] = '{8'h53, 8'h2D, 8'h4D, 8'h53, 8'h55, 8'h2D, 8'h31, 8'h7F,
                             8'h80, 8'h01, 8'hFE, 8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'hE7};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [7:0] d);
        bus.wren = 1; bus.wraddress = a; bus.data = d;
        step();
        bus.wren = 0;
    endtask

    task automatic rd(input string tag, input logic [13:0] a, input logic [7:0] exp);
        bus.rdaddress = a;
        repeat (LAT) step();
        chk(tag, bus.q, exp);
    endtask

    initial begin
        bus.wren = 0; bus.wraddress = '0; bus.data = '0; bus.rdaddress = '0;
        repeat (3) step();
        chk("reset_q0", bus.q, 8'h00);
        bus.rdaddress = 14'h3FFF;
        step();
        chk("reset_q_held", bus.q, 8'h00);
        reset = 0;
        rd("rd_0000_init", 14'h0000, 8'h00);
        rd("rd_3fff_init", 14'h3FFF, 8'h00);

        for (int i = 0; i < 16; i++) wr(14'(i), pat[i]);
        for (int i = 0; i < 16 + LAT - 1; i++) begin
            if (i < 16) bus.rdaddress = 14'(i);
            step();
            if (i >= LAT - 1) chk($sformatf("stream_%0d", i - LAT + 1), bus.q, pat[i - LAT + 1]);
        end

        wr(14'h1234, 8'h55);
        bus.wren = 1; bus.wraddress = 14'h1234; bus.data = 8'hAA; bus.rdaddress = 14'h1234;
        step();
        bus.wren = 0;
        repeat (LAT - 1) step();
        chk("rdw_old", bus.q, 8'h55);
        rd("rdw_new", 14'h1234, 8'hAA);

        wr(14'h3FFF, 8'h31);
        wr(14'h0000, 8'h99);
        rd("edge_3fff", 14'h3FFF, 8'h31);
        rd("edge_0000", 14'h0000, 8'h99);

        wr(14'h0100, 8'h7E);
        bus.rdaddress = 14'h0100;
        step();
        reset = 1;
        step();
        chk("mid_reset_q0", bus.q, 8'h00);
        wr(14'h0300, 8'h44);
        chk("reset_write_q0", bus.q, 8'h00);
        step();
        chk("reset_hold_q0", bus.q, 8'h00);
        reset = 0;
        rd("retain_0100", 14'h0100, 8'h7E);
        rd("reset_wr_0300", 14'h0300, 8'h44);

        wr(14'h0200, 8'h12);
        bus.wren = 0; bus.wraddress = 14'h0200; bus.data = 8'hFF;
        step();
        rd("no_wren_0200", 14'h0200, 8'h12);
        rd("neighbor_000f", 14'h000F, pat[15]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
